pmem_burst_bridge: RTL

Responder on the 256-bit physical-memory line interface driven by the cache arbiter. It serves whole-line reads and writes by running 4-beat, 64-bit bursts on a narrower backing-memory bus. It gathers or scatters the beats, returns one `pmem_resp` per line, and reports backing-bus errors or timeouts through `pmem_error`. It sits between the cache hierarchy's `pmem_*` port and the off-chip/SRAM memory controller.

---
 rtl/pmem_burst_bridge_pkg.sv | 18 +
 rtl/burst_line_buffer.sv | 48 ++++
 rtl/pmem_burst_bridge.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pmem_burst_bridge_pkg.sv
// Shared types for the pmem line interface and the burst bridge FSM.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    localparam int LINE_W = 256;
    localparam int BEATS  = 4;

    typedef logic [LINE_W-1:0] pmem_line_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } burst_state_t;

endpackage

// File: rtl/burst_line_buffer.sv
// 256-bit line register: whole-line load or clear, beat-sliced write for
// gathering read beats, and a beat-indexed mux for scattering write beats.
module burst_line_buffer
    import rv32i_types::*;
#(
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  pmem_line_t        load_line,
    input  logic              beat_we,
    input  logic [1:0]        beat_idx,
    input  logic [BEAT_W-1:0] beat_data,
    input  logic [1:0]        mux_idx,
    output logic [BEAT_W-1:0] mux_beat,
    output pmem_line_t        line
);

    pmem_line_t line_q;
    pmem_line_t line_d;

    always_comb begin
        line_d = line_q;
        if (clear) begin
            line_d = '0;
        end else if (load) begin
            line_d = load_line;
        end else if (beat_we) begin
            line_d[beat_idx*BEAT_W +: BEAT_W] = beat_data;
        end
    end

    // NOTE: the line is a plain register (not a RAM), so it is reset; the
    // read line must read back as zero straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign mux_beat = line_q[mux_idx*BEAT_W +: BEAT_W];
    assign line     = line_q;

endmodule

// File: rtl/pmem_burst_bridge.sv
// Serves 256-bit pmem line reads/writes as 4-beat 64-bit bursts on the
// backing-memory bus, with per-beat timeout and error reporting.
module pmem_burst_bridge
    import rv32i_types::*;
#(
    parameter int BEAT_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  rv32i_word         pmem_address,
    input  pmem_line_t        pmem_wdata,
    output logic              pmem_resp,
    output logic              pmem_error,
    output pmem_line_t        pmem_rdata,
    output logic              bmem_read,
    output logic              bmem_write,
    output rv32i_word         bmem_address,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_resp,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_error
);

    localparam int              TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    burst_state_t      state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    rv32i_word         addr_q, addr_d;
    logic [BEAT_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              resp_q, resp_d;
    logic              err_q, err_d;

    logic              buf_clear;
    logic              buf_load;
    logic              buf_we;
    logic [1:0]        next_idx;
    logic [BEAT_W-1:0] next_beat;

    // Only consulted while beat_q < 3, so the wrap to 0 never matters.
    assign next_idx = beat_q + 2'd1;

    burst_line_buffer #(
        .BEAT_W (BEAT_W)
    ) u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .clear     (buf_clear),
        .load      (buf_load),
        .load_line (pmem_wdata),
        .beat_we   (buf_we),
        .beat_idx  (beat_q),
        .beat_data (bmem_rdata),
        .mux_idx   (next_idx),
        .mux_beat  (next_beat),
        .line      (pmem_rdata)
    );

    // NOTE: every variable driven here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        tmo_d     = tmo_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = 1'b0;
        buf_clear = 1'b0;
        buf_load  = 1'b0;
        buf_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pmem_read && pmem_write) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (pmem_read) begin
                    state_d   = RD;
                    addr_d    = pmem_address & ~32'h1F;
                    beat_d    = '0;
                    tmo_d     = '0;
                    buf_clear = 1'b1;
                end else if (pmem_write) begin
                    state_d  = WR;
                    addr_d   = pmem_address & ~32'h1F;
                    beat_d   = '0;
                    tmo_d    = '0;
                    buf_load = 1'b1;
                    wdata_d  = pmem_wdata[BEAT_W-1:0];
                end
            end
            RD, WR: begin
                if (bmem_resp) begin
                    tmo_d = '0;
                    if (bmem_error) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        buf_we = (state_q == RD);
                        if (beat_q == 2'd3) begin
                            state_d = DONE;
                        end else begin
                            beat_d  = next_idx;
                            wdata_d = (state_q == WR) ? next_beat : wdata_q;
                        end
                    end
                end else if (tmo_q == TMO_MAX) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_d   = (state_d == RD);
        wr_d   = (state_d == WR);
        resp_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    assign pmem_resp    = resp_q;
    assign pmem_error   = err_q;
    assign bmem_read    = rd_q;
    assign bmem_write   = wr_q;
    assign bmem_address = addr_q;
    assign bmem_wdata   = wdata_q;

endmodule
